trigger_qual: RTL and testbench

TRIGGER_QUAL -- requirements
Module: trigger_qual

---
 rtl/trigger_qual.sv | 184 ++++++++++++++++++
 tb/tb_trigger_qual.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_qual.sv
// trigger_qual: qualifies a raw asynchronous trigger input and emits a single
// registered trigger pulse on the N-th filtered edge of the selected polarity.
//
// Ports:
//   clk       single clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   trig_in   raw asynchronous trigger from the target pin
//   arm       one-cycle request to arm (ignored unless idle)
//   disarm    abort request, returns to idle; overrides arm
//   trig_out  one-cycle qualified trigger pulse
//   armed     high while waiting for qualifying edges
//   done      sticky one-shot completion flag
//   edge_cnt  qualifying edges counted since arming (saturating)
module trigger_qual #(
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned EDGE_COUNT     = 1,
  parameter int unsigned POLARITY       = 1,
  parameter int unsigned HOLDOFF_CYCLES = 12,
  parameter int unsigned REARM          = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig_in,
  input  logic        arm,
  input  logic        disarm,
  output logic        trig_out,
  output logic        armed,
  output logic        done,
  output logic [15:0] edge_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FILT_W = 8;
  localparam int unsigned HO_W   = 32;

  // Inactive input level; every input-side flop resets here so reset release
  // with an idle pin cannot manufacture an edge.
  localparam logic              IDLE_LVL  = (POLARITY == 0) ? 1'b1 : 1'b0;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W:0]    EDGE_TGT  = (EDGE_COUNT == 0) ? 17'd1 : 17'(EDGE_COUNT);
  localparam logic [HO_W-1:0]   HO_LOAD   = HO_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              sync1;
  logic              trig_s;
  logic              filt;
  logic              filt_d;
  logic [FILT_W-1:0] filt_cnt;

  logic [HO_W-1:0]   ho_cnt;
  logic [HO_W-1:0]   ho_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              trig_nxt;
  logic              done_nxt;

  logic              qual_edge;
  logic [CNT_W:0]    cnt_sum;
  logic              fire_hit;
  logic [CNT_W-1:0]  cnt_sat;
  logic              ho_last;

  // Two-flop synchronizer plus persistence filter on the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= IDLE_LVL;
      trig_s   <= IDLE_LVL;
      filt     <= IDLE_LVL;
      filt_d   <= IDLE_LVL;
      filt_cnt <= '0;
    end else begin
      sync1  <= trig_in;
      trig_s <= sync1;
      filt_d <= filt;
      if (trig_s == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= trig_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  // A qualifying edge is a filtered transition away from the idle level.
  assign qual_edge = (filt != filt_d) && (filt != IDLE_LVL);

  // Firing compares the unsaturated increment so the target is always reachable.
  assign cnt_sum  = {1'b0, edge_cnt} + 17'd1;
  assign fire_hit = (cnt_sum == EDGE_TGT);
  assign cnt_sat  = (edge_cnt == 16'hFFFF) ? edge_cnt : cnt_sum[CNT_W-1:0];
  assign ho_last  = (ho_cnt <= 32'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; disarm wins over everything else.
  always_comb begin
    state_nxt = state;
    if (disarm) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (arm) state_nxt = ST_ARMED;
        ST_ARMED:   if (qual_edge && fire_hit) state_nxt = ST_HOLDOFF;
        ST_HOLDOFF: if (ho_last) state_nxt = (REARM != 0) ? ST_ARMED : ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the holdoff counter.
  always_comb begin
    trig_nxt = 1'b0;
    done_nxt = done;
    cnt_nxt  = edge_cnt;
    ho_nxt   = ho_cnt;
    if (disarm) begin
      done_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            cnt_nxt  = '0;
            done_nxt = 1'b0;
          end
        end
        ST_ARMED: begin
          if (qual_edge) begin
            cnt_nxt = cnt_sat;
            if (fire_hit) begin
              trig_nxt = 1'b1;
              ho_nxt   = HO_LOAD;
            end
          end
        end
        ST_HOLDOFF: begin
          if (ho_last) begin
            if (REARM != 0) begin
              cnt_nxt = '0;
            end else begin
              done_nxt = 1'b1;
            end
          end else begin
            ho_nxt = ho_cnt - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_out <= 1'b0;
      armed    <= 1'b0;
      done     <= 1'b0;
      edge_cnt <= '0;
      ho_cnt   <= '0;
    end else begin
      trig_out <= trig_nxt;
      armed    <= (state_nxt == ST_ARMED);
      done     <= done_nxt;
      edge_cnt <= cnt_nxt;
      ho_cnt   <= ho_nxt;
    end
  end

endmodule

// File: tb/tb_trigger_qual.sv
// Testbench for trigger_qual: scenario table, hand-written corner sequences
// and a randomized run checked against a behavioural model of the default DUT.
module tb_trigger_qual;

  localparam int D_F  = 4;
  localparam int D_EC = 1;
  localparam int D_HO = 12;

  logic        clk;
  logic        rst_n;
  logic        trig_in, arm, disarm;
  logic        trig_out, armed, done;
  logic [15:0] edge_cnt;
  logic        trig_r, arm_r, disarm_r;
  logic        trig_out_r, armed_r, done_r;
  logic [15:0] edge_cnt_r;
  logic        trig_p, arm_p, disarm_p;
  logic        trig_out_p, armed_p, done_p;
  logic [15:0] edge_cnt_p;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 0;

  trigger_qual u_dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .arm(arm), .disarm(disarm),
    .trig_out(trig_out), .armed(armed), .done(done), .edge_cnt(edge_cnt)
  );

  trigger_qual #(.EDGE_COUNT(3), .REARM(1)) u_r (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_r), .arm(arm_r), .disarm(disarm_r),
    .trig_out(trig_out_r), .armed(armed_r), .done(done_r), .edge_cnt(edge_cnt_r)
  );

  trigger_qual #(.POLARITY(0)) u_p (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_p), .arm(arm_p), .disarm(disarm_p),
    .trig_out(trig_out_p), .armed(armed_p), .done(done_p), .edge_cnt(edge_cnt_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the default-parameter DUT.
  // mode: 0 idle, 1 armed, 2 holdoff. The filter accepts a new level once the
  // synchronized input has disagreed with it for D_F cycles in a row; the
  // accepted level is reported as an edge one cycle later.
  int m_mode, m_run, m_lvl, m_s1, m_ts, m_pend, m_cnt, m_trig, m_done, m_ho;

  task automatic model_step();
    int nxt;
    m_trig = 0;
    if (disarm) begin
      m_mode = 0;
      m_done = 0;
    end else if (m_mode == 0) begin
      if (arm) begin
        m_mode = 1;
        m_cnt  = 0;
        m_done = 0;
      end
    end else if (m_mode == 1) begin
      if (m_pend != 0) begin
        nxt = m_cnt + 1;
        if (nxt == D_EC) begin
          m_trig = 1;
          m_mode = 2;
          m_ho   = (D_HO == 0) ? 1 : D_HO;
        end
        m_cnt = (nxt > 65535) ? 65535 : nxt;
      end
    end else begin
      m_ho = m_ho - 1;
      if (m_ho == 0) begin
        m_mode = 0;
        m_done = 1;
      end
    end
    m_pend = 0;
    if (m_ts != m_lvl) begin
      m_run = m_run + 1;
      if (m_run == D_F) begin
        m_lvl  = m_ts;
        m_run  = 0;
        m_pend = (m_lvl == 1) ? 1 : 0;
      end
    end else begin
      m_run = 0;
    end
    m_ts = m_s1;
    m_s1 = trig_in ? 1 : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_run = 0; m_lvl = 0; m_s1 = 0; m_ts = 0;
      m_pend = 0; m_cnt = 0; m_trig = 0; m_done = 0; m_ho = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model trig_out", 32'(trig_out), 32'(m_trig));
      check("model armed", 32'(armed), (m_mode == 1) ? 32'd1 : 32'd0);
      check("model done", 32'(done), 32'(m_done));
      check("model edge_cnt", 32'(edge_cnt), 32'(m_cnt));
    end
  end

  typedef struct {
    int   hold;
    int   exp_pulses;
    int   exp_first;
    logic exp_armed;
    logic exp_done;
    int   exp_cnt;
  } row_t;

  row_t rows[5];

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic arm_pulse();
    @(negedge clk); #1 arm = 1'b1;
    @(negedge clk); #1 arm = 1'b0;
  endtask

  task automatic run_row(input int idx, input row_t r);
    int pulses;
    int first;
    string tag;
    pulses = 0;
    first  = 0;
    tag = $sformatf("row%0d", idx);
    do_reset();
    arm_pulse();
    @(negedge clk); #1 trig_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (trig_out) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == r.hold) trig_in = 1'b0;
    end
    check({tag, " pulses"}, 32'(pulses), 32'(r.exp_pulses));
    check({tag, " fire edge"}, 32'(first), 32'(r.exp_first));
    check({tag, " armed"}, 32'(armed), 32'(r.exp_armed));
    check({tag, " done"}, 32'(done), 32'(r.exp_done));
    check({tag, " edge_cnt"}, 32'(edge_cnt), 32'(r.exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;
    int fire_win;
    int hold;
    int exp_r[5];

    rst_n = 1'b0;
    trig_in = 1'b0; arm = 1'b0; disarm = 1'b0;
    trig_r = 1'b0; arm_r = 1'b0; disarm_r = 1'b0;
    trig_p = 1'b1; arm_p = 1'b0; disarm_p = 1'b0;

    // hold, pulses, first fire edge, armed, done, edge_cnt after 40 cycles
    rows[0] = '{1,  0, 0, 1'b1, 1'b0, 0};
    rows[1] = '{3,  0, 0, 1'b1, 1'b0, 0};
    rows[2] = '{4,  1, 7, 1'b0, 1'b1, 1};
    rows[3] = '{6,  1, 7, 1'b0, 1'b1, 1};
    rows[4] = '{10, 1, 7, 1'b0, 1'b1, 1};

    repeat (3) @(negedge clk);
    #1;
    check("reset trig_out", 32'(trig_out), 32'd0);
    check("reset armed", 32'(armed), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset edge_cnt", 32'(edge_cnt), 32'd0);
    rst_n = 1'b1;
    model_on = 1'b1;

    for (int i = 0; i < 5; i++) run_row(i, rows[i]);

    // One-shot timing: pulse on edge 7, one cycle wide, done after 12 holdoff cycles.
    do_reset();
    arm_pulse();
    @(negedge clk); #1 trig_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        check("pre-fire trig_out", 32'(trig_out), 32'd0);
        check("pre-fire armed", 32'(armed), 32'd1);
      end
      if (k == 7) begin
        check("fire trig_out", 32'(trig_out), 32'd1);
        check("fire armed", 32'(armed), 32'd0);
      end
      if (k == 8) check("pulse width", 32'(trig_out), 32'd0);
      if (k == 18) check("holdoff done low", 32'(done), 32'd0);
      if (k == 19) check("holdoff done high", 32'(done), 32'd1);
      if (k == 10) trig_in = 1'b0;
    end
    @(negedge clk); #1 disarm = 1'b1;
    @(negedge clk); #1 disarm = 1'b0;
    check("disarm clears done", 32'(done), 32'd0);
    check("disarm holds edge_cnt", 32'(edge_cnt), 32'd1);

    // Arm and disarm in the same cycle stays idle.
    @(negedge clk); #1 arm = 1'b1; disarm = 1'b1;
    @(negedge clk); #1 arm = 1'b0; disarm = 1'b0;
    check("arm+disarm armed", 32'(armed), 32'd0);

    // Disarm coinciding with the firing edge suppresses the pulse.
    do_reset();
    arm_pulse();
    @(negedge clk); #1 trig_in = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (trig_out) pulses++;
      if (k == 7) begin
        check("disarm-fire armed", 32'(armed), 32'd0);
        check("disarm-fire done", 32'(done), 32'd0);
        check("disarm-fire edge_cnt", 32'(edge_cnt), 32'd0);
        disarm = 1'b0;
      end
      if (k == 6) disarm = 1'b1;
    end
    check("disarm-fire pulses", 32'(pulses), 32'd0);
    @(negedge clk); #1 trig_in = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of holdoff aborts at once with no later pulse.
    do_reset();
    arm_pulse();
    @(negedge clk); #1 trig_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 7) check("pre-reset fire", 32'(trig_out), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("mid-holdoff rst trig_out", 32'(trig_out), 32'd0);
    check("mid-holdoff rst armed", 32'(armed), 32'd0);
    check("mid-holdoff rst done", 32'(done), 32'd0);
    check("mid-holdoff rst edge_cnt", 32'(edge_cnt), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (trig_out) pulses++;
    end
    check("post-reset pulses", 32'(pulses), 32'd0);
    check("post-reset armed", 32'(armed), 32'd0);
    trig_in = 1'b0;

    // EDGE_COUNT=3 with rearm: five edges 40 cycles apart.
    exp_r = '{1, 2, 0, 1, 2};
    do_reset();
    @(negedge clk); #1 arm_r = 1'b1;
    @(negedge clk); #1 arm_r = 1'b0;
    pulses = 0;
    fire_win = 0;
    for (int e = 0; e < 5; e++) begin
      trig_r = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (trig_out_r) begin
          pulses++;
          fire_win = e + 1;
        end
        if (k == 10) trig_r = 1'b0;
      end
      check($sformatf("rearm edge_cnt after edge %0d", e + 1), 32'(edge_cnt_r), 32'(exp_r[e]));
    end
    check("rearm pulses", 32'(pulses), 32'd1);
    check("rearm fire edge", 32'(fire_win), 32'd3);
    check("rearm armed", 32'(armed_r), 32'd1);
    check("rearm done", 32'(done_r), 32'd0);

    // Falling polarity: idle high, falling edge fires, rising edge does not.
    do_reset();
    @(negedge clk); #1 arm_p = 1'b1;
    @(negedge clk); #1 arm_p = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (trig_out_p) pulses++;
    end
    check("pol0 idle pulses", 32'(pulses), 32'd0);
    check("pol0 idle edge_cnt", 32'(edge_cnt_p), 32'd0);
    trig_p = 1'b0;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (trig_out_p && first == 0) first = k;
    end
    check("pol0 falling fire edge", 32'(first), 32'd7);
    check("pol0 done", 32'(done_p), 32'd1);
    @(negedge clk); #1 arm_p = 1'b1;
    @(negedge clk); #1 arm_p = 1'b0;
    check("pol0 rearm armed", 32'(armed_p), 32'd1);
    check("pol0 arm clears done", 32'(done_p), 32'd0);
    trig_p = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (trig_out_p) pulses++;
    end
    check("pol0 rising pulses", 32'(pulses), 32'd0);
    check("pol0 rising edge_cnt", 32'(edge_cnt_p), 32'd0);
    check("pol0 rising armed", 32'(armed_p), 32'd1);

    // Randomized run on the default DUT against the model.
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (hold == 0) begin
        trig_in = ~trig_in;
        hold = $urandom_range(1, 12);
      end
      hold--;
      arm    = ($urandom_range(0, 15) == 0);
      disarm = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk); #1 arm = 1'b0; disarm = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
